jtdd_rom_arb: RTL and testbench



---
 rtl/jtdd_rom_arb.sv | 163 ++++++++++++++++
 tb/tb_jtdd_rom_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_rom_arb.sv
// ROM arbiter for the Double Dragon core. Three requesters (main CPU, sound CPU, MCU)
// share one SDRAM read port. Each keeps a one-word cache line that answers hits
// combinationally. Misses are served one at a time, granted round-robin.
module jtdd_rom_arb #(
    parameter int unsigned    AW0  = 18,
    parameter int unsigned    AW1  = 15,
    parameter int unsigned    AW2  = 14,
    parameter int unsigned    SDW  = 22,
    parameter logic [SDW-1:0] OFF0 = 22'h00000,
    parameter logic [SDW-1:0] OFF1 = 22'h20000,
    parameter logic [SDW-1:0] OFF2 = 22'h24000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           main_cs,
    input  logic [AW0-1:0] main_addr,
    output logic [7:0]     main_data,
    output logic           main_ok,
    input  logic           snd_cs,
    input  logic [AW1-1:0] snd_addr,
    output logic [7:0]     snd_data,
    output logic           snd_ok,
    input  logic           mcu_cs,
    input  logic [AW2-1:0] mcu_addr,
    output logic [7:0]     mcu_data,
    output logic           mcu_ok,
    output logic           sdram_req,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           sdram_dok,
    input  logic [15:0]    sdram_din
);

    // Tag widths; the captured tag register is as wide as the widest of them.
    localparam int unsigned TW0 = AW0 - 1;
    localparam int unsigned TW1 = AW1 - 1;
    localparam int unsigned TW2 = AW2 - 1;
    localparam int unsigned TWM = (TW0 > TW1) ? ((TW0 > TW2) ? TW0 : TW2)
                                              : ((TW1 > TW2) ? TW1 : TW2);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitData} state_e;

    state_e         state_q;
    logic [1:0]     gnt_q, last_q, gnt_d;
    logic [TWM-1:0] cap_tag_q, sel_tag;
    logic [SDW-1:0] sel_off;
    logic [SDW-1:0] addr_q;
    logic           req_q;
    logic [TW0-1:0] tag0_q;
    logic [TW1-1:0] tag1_q;
    logic [TW2-1:0] tag2_q;
    logic [15:0]    word0_q, word1_q, word2_q;
    logic [2:0]     valid_q;
    logic [2:0]     hit, pend;
    logic           fill;

    assign hit[0] = main_cs & valid_q[0] & (main_addr[AW0-1:1] == tag0_q);
    assign hit[1] = snd_cs  & valid_q[1] & (snd_addr[AW1-1:1]  == tag1_q);
    assign hit[2] = mcu_cs  & valid_q[2] & (mcu_addr[AW2-1:1]  == tag2_q);
    assign pend   = {mcu_cs, snd_cs, main_cs} & ~hit;

    assign main_ok   = hit[0];
    assign snd_ok    = hit[1];
    assign mcu_ok    = hit[2];
    assign main_data = main_addr[0] ? word0_q[15:8] : word0_q[7:0];
    assign snd_data  = snd_addr[0]  ? word1_q[15:8] : word1_q[7:0];
    assign mcu_data  = mcu_addr[0]  ? word2_q[15:8] : word2_q[7:0];

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    // Data arriving together with the ack still completes the fill.
    assign fill = ((state_q == StWaitData) & sdram_dok) |
                  ((state_q == StWaitAck) & sdram_ack & sdram_dok);

    // Round-robin pick starting after the last served requester, plus its tag and offset.
    always_comb begin
        gnt_d = 2'd0;
        unique case (last_q)
            2'd0:    gnt_d = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
            2'd1:    gnt_d = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
            default: gnt_d = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        endcase
        sel_tag = '0;
        sel_off = '0;
        unique case (gnt_d)
            2'd0: begin
                sel_tag = TWM'(main_addr[AW0-1:1]);
                sel_off = OFF0;
            end
            2'd1: begin
                sel_tag = TWM'(snd_addr[AW1-1:1]);
                sel_off = OFF1;
            end
            default: begin
                sel_tag = TWM'(mcu_addr[AW2-1:1]);
                sel_off = OFF2;
            end
        endcase
    end

    // Request FSM and cache fill; the fill always lands in the tag captured at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 2'd0;
            last_q    <= 2'd2;
            cap_tag_q <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            tag0_q    <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
            word2_q   <= '0;
            valid_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|pend) begin
                        gnt_q     <= gnt_d;
                        cap_tag_q <= sel_tag;
                        addr_q    <= sel_off + SDW'(sel_tag);
                        req_q     <= 1'b1;
                        state_q   <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= sdram_dok ? StIdle : StWaitData;
                    end
                end
                StWaitData: begin
                    if (sdram_dok) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (fill) begin
                last_q <= gnt_q;
                unique case (gnt_q)
                    2'd0: begin
                        word0_q    <= sdram_din;
                        tag0_q     <= cap_tag_q[TW0-1:0];
                        valid_q[0] <= 1'b1;
                    end
                    2'd1: begin
                        word1_q    <= sdram_din;
                        tag1_q     <= cap_tag_q[TW1-1:0];
                        valid_q[1] <= 1'b1;
                    end
                    default: begin
                        word2_q    <= sdram_din;
                        tag2_q     <= cap_tag_q[TW2-1:0];
                        valid_q[2] <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for jtdd_rom_arb with hand-driven SDRAM ack/dok.
module tb_jtdd_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_cs, snd_cs, mcu_cs;
    logic [17:0] main_addr;
    logic [14:0] snd_addr;
    logic [13:0] mcu_addr;
    logic [7:0]  main_data, snd_data, mcu_data;
    logic        main_ok, snd_ok, mcu_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, sdram_dok;
    logic [15:0] sdram_din;

    int checks   = 0;
    int failures = 0;
    int req_count = 0;
    int cnt;
    logic req_prev = 1'b0;

    jtdd_rom_arb dut (
        .clk        (clk),
        .rst        (rst),
        .main_cs    (main_cs),
        .main_addr  (main_addr),
        .main_data  (main_data),
        .main_ok    (main_ok),
        .snd_cs     (snd_cs),
        .snd_addr   (snd_addr),
        .snd_data   (snd_data),
        .snd_ok     (snd_ok),
        .mcu_cs     (mcu_cs),
        .mcu_addr   (mcu_addr),
        .mcu_data   (mcu_data),
        .mcu_ok     (mcu_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    // Count issued SDRAM requests (rising edges of req).
    always @(posedge clk) begin
        if (sdram_req && !req_prev) req_count++;
        req_prev <= sdram_req;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!sdram_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 32'(sdram_req), 32'd1);
    endtask

    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [15:0] din);
        wait_req(tag);
        check({tag, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        sdram_din = din;
        sdram_dok = 1'b1;
        step();
        sdram_dok = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        main_cs = 1'b0; snd_cs = 1'b0; mcu_cs = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        main_cs = 1'b0; snd_cs = 1'b0; mcu_cs = 1'b0;
        main_addr = '0; snd_addr = '0; mcu_addr = '0;
        sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_din = '0;
        step();
        step();
        // Reset state: addr 0 matches the reset tag, so only valid=0 keeps ok low.
        main_cs = 1'b1; snd_cs = 1'b1; mcu_cs = 1'b1;
        #1;
        check("rst_main_ok", 32'(main_ok), 0);
        check("rst_snd_ok", 32'(snd_ok), 0);
        check("rst_mcu_ok", 32'(mcu_ok), 0);
        check("rst_req", 32'(sdram_req), 0);
        check("rst_addr", 32'(sdram_addr), 0);
        main_cs = 1'b0; snd_cs = 1'b0; mcu_cs = 1'b0;
        rst = 1'b0;
        step();

        // Basic main miss, fill and same-word hit.
        main_cs = 1'b1; main_addr = 18'h00005;
        #1;
        check("t1_req_n", 32'(sdram_req), 0);
        step();
        check("t1_req_n1", 32'(sdram_req), 1);
        check("t1_addr", 32'(sdram_addr), 32'h00002);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        check("t1_req_drop", 32'(sdram_req), 0);
        sdram_din = 16'hA55A; sdram_dok = 1'b1;
        #1;
        check("t1_ok_at_dok", 32'(main_ok), 0);
        step();
        sdram_dok = 1'b0;
        #1;
        check("t1_ok", 32'(main_ok), 1);
        check("t1_data_hi", 32'(main_data), 32'hA5);
        cnt = req_count;
        main_addr = 18'h00004;
        #1;
        check("t1_ok_lo", 32'(main_ok), 1);
        check("t1_data_lo", 32'(main_data), 32'h5A);
        step();
        step();
        check("t1_no_req", 32'(req_count - cnt), 0);

        // Three-way simultaneous miss: main, snd, mcu, then main again.
        do_reset();
        main_cs = 1'b1; main_addr = 18'h00101;
        snd_cs = 1'b1; snd_addr = 15'h0011;
        mcu_cs = 1'b1; mcu_addr = 14'h0021;
        serve("rr0", 22'h00080, 16'h1234);
        check("rr0_ok", 32'(main_ok), 1);
        check("rr0_data", 32'(main_data), 32'h12);
        check("rr0_snd_ok", 32'(snd_ok), 0);
        serve("rr1", 22'h20008, 16'h5678);
        check("rr1_ok", 32'(snd_ok), 1);
        check("rr1_data", 32'(snd_data), 32'h56);
        serve("rr2", 22'h24010, 16'h9ABC);
        check("rr2_ok", 32'(mcu_ok), 1);
        check("rr2_data", 32'(mcu_data), 32'h9A);
        main_addr = 18'h00200;
        serve("rr3", 22'h00100, 16'hDEF0);
        check("rr3_ok", 32'(main_ok), 1);
        check("rr3_data", 32'(main_data), 32'hF0);

        // snd_cs dropped between ack and dok: fill still completes.
        snd_addr = 15'h7FFF;
        wait_req("drop");
        check("drop_addr", 32'(sdram_addr), 32'h23FFF);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        snd_cs = 1'b0;
        step();
        sdram_din = 16'hCAFE; sdram_dok = 1'b1;
        step();
        sdram_dok = 1'b0;
        #1;
        check("drop_ok_off", 32'(snd_ok), 0);
        cnt = req_count;
        snd_cs = 1'b1;
        #1;
        check("drop_ok", 32'(snd_ok), 1);
        check("drop_data", 32'(snd_data), 32'hCA);
        step();
        step();
        step();
        check("drop_no_req", 32'(req_count - cnt), 0);

        // ack and dok in the same cycle.
        mcu_addr = 14'h3FFE;
        wait_req("same");
        check("same_addr", 32'(sdram_addr), 32'h25FFF);
        sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_din = 16'h0F1E;
        #1;
        check("same_ok_early", 32'(mcu_ok), 0);
        step();
        sdram_ack = 1'b0; sdram_dok = 1'b0;
        #1;
        check("same_ok", 32'(mcu_ok), 1);
        check("same_data", 32'(mcu_data), 32'h1E);
        check("same_req", 32'(sdram_req), 0);
        step();
        check("same_idle", 32'(sdram_req), 0);

        // Reset in WAIT_DATA, then stray dok.
        main_addr = 18'h00300;
        wait_req("rstw");
        check("rstw_addr", 32'(sdram_addr), 32'h00180);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        step();
        rst = 1'b1;
        main_cs = 1'b0; snd_cs = 1'b0; mcu_cs = 1'b0;
        step();
        rst = 1'b0;
        sdram_din = 16'hBEEF; sdram_dok = 1'b1;
        step();
        sdram_dok = 1'b0;
        main_cs = 1'b1; snd_cs = 1'b1; mcu_cs = 1'b1;
        #1;
        check("rstw_main_ok", 32'(main_ok), 0);
        check("rstw_snd_ok", 32'(snd_ok), 0);
        check("rstw_mcu_ok", 32'(mcu_ok), 0);
        check("rstw_req0", 32'(sdram_req), 0);
        snd_cs = 1'b0; mcu_cs = 1'b0;
        step();
        check("rstw_fresh_req", 32'(sdram_req), 1);
        serve("rstw_refill", 22'h00180, 16'h4455);
        check("rstw_ok", 32'(main_ok), 1);
        check("rstw_data", 32'(main_data), 32'h55);

        // Back-to-back main misses with snd pending: snd served in between.
        main_addr = 18'h00400;
        step();
        snd_cs = 1'b1; snd_addr = 15'h0002;
        serve("b2b_m0", 22'h00200, 16'h0102);
        check("b2b_m0_ok", 32'(main_ok), 1);
        check("b2b_m0_data", 32'(main_data), 32'h02);
        main_addr = 18'h00500;
        serve("b2b_snd", 22'h20001, 16'h0304);
        check("b2b_snd_ok", 32'(snd_ok), 1);
        check("b2b_snd_data", 32'(snd_data), 32'h04);
        check("b2b_main_wait", 32'(main_ok), 0);
        serve("b2b_m1", 22'h00280, 16'h0506);
        check("b2b_m1_ok", 32'(main_ok), 1);
        check("b2b_m1_data", 32'(main_data), 32'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
